// File: rtl/avalon_st_pkg.sv
// rtl/avalon_st_pkg.sv - shared Avalon-ST framing types for the sequence source and merge stages
package avalon_st_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SOP  = 4'b0010,
        DATA = 4'b0100,
        EOP  = 4'b1000
    } state_t;

    typedef enum logic [1:0] {
        BEAT_SOP,
        BEAT_DATA,
        BEAT_EOP
    } beat_kind_t;

    function automatic beat_kind_t beat_kind(input logic sop, input logic eop);
        if (sop) return BEAT_SOP;
        if (eop) return BEAT_EOP;
        return BEAT_DATA;
    endfunction

endpackage

// File: rtl/sequence_source_avalon_st_if.sv
// rtl/sequence_source_avalon_st_if.sv - command and Avalon-ST output bundle of the sequence source
interface sequence_source_avalon_st_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [DATA_WIDTH-1:0]  cmd_start;
    logic [COUNT_WIDTH-1:0] cmd_count;
    logic                   out_ready;
    logic                   out_valid;
    logic                   out_startofpacket;
    logic                   out_endofpacket;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   busy;

    modport master (
        input  cmd_valid, cmd_start, cmd_count, out_ready,
        output cmd_ready, out_valid, out_startofpacket, out_endofpacket, out_data, busy
    );

    modport slave (
        output cmd_valid, cmd_start, cmd_count, out_ready,
        input  cmd_ready, out_valid, out_startofpacket, out_endofpacket, out_data, busy
    );
endinterface

// File: rtl/sequence_source_avalon_st.sv
// rtl/sequence_source_avalon_st.sv - SOP/data/EOP packet generator; SEQUENCE_SOURCE_CHECKSUM_EN selects checksum trailer
module sequence_source_avalon_st
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int STEP        = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    sequence_source_avalon_st_if.master bus
);

    localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);

    state_t                 state_q, state_n;
    logic [DATA_WIDTH-1:0]  value_q, value_n;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_n;
    logic                   valid_q, valid_n;
    logic                   sop_q, sop_n;
    logic                   eop_q, eop_n;
    logic [DATA_WIDTH-1:0]  data_q, data_n;
    logic [DATA_WIDTH-1:0]  count_header;
    logic [DATA_WIDTH-1:0]  trailer_last;
    logic                   xfer;

`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  checksum_q, checksum_n;
    // Trailer as it will stand once the final data beat has been added in.
    assign trailer_last = checksum_q + value_q;
`else
    logic [DATA_WIDTH-1:0]  sent_q, sent_n;
    assign trailer_last = sent_q + 1'b1;
`endif

    generate
        if (COUNT_WIDTH >= DATA_WIDTH) begin : g_header_trunc
            assign count_header = bus.cmd_count[DATA_WIDTH-1:0];
        end else begin : g_header_zext
            assign count_header = {{(DATA_WIDTH-COUNT_WIDTH){1'b0}}, bus.cmd_count};
        end
    endgenerate

    assign xfer                  = valid_q && bus.out_ready;
    assign bus.cmd_ready         = (state_q == IDLE);
    assign bus.busy              = (state_q != IDLE);
    assign bus.out_valid         = valid_q;
    assign bus.out_startofpacket = sop_q;
    assign bus.out_endofpacket   = eop_q;
    assign bus.out_data          = data_q;

    always_comb begin
        state_n     = state_q;
        value_n     = value_q;
        remaining_n = remaining_q;
        valid_n     = valid_q;
        sop_n       = sop_q;
        eop_n       = eop_q;
        data_n      = data_q;
`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
        checksum_n  = checksum_q;
`else
        sent_n      = sent_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    value_n     = bus.cmd_start;
                    remaining_n = bus.cmd_count;
`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
                    checksum_n  = '0;
`else
                    sent_n      = '0;
`endif
                    state_n     = SOP;
                    valid_n     = 1'b1;
                    sop_n       = 1'b1;
                    eop_n       = 1'b0;
                    data_n      = count_header;
                end
            end
            SOP: begin
                if (xfer) begin
                    sop_n = 1'b0;
                    if (remaining_q == '0) begin
                        // Empty packet: trailer is zero in either build.
                        state_n = EOP;
                        eop_n   = 1'b1;
                        data_n  = '0;
                    end else begin
                        state_n = DATA;
                        data_n  = value_q;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    value_n     = value_q + STEP_W;
                    remaining_n = remaining_q - 1'b1;
`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
                    checksum_n  = checksum_q + value_q;
`else
                    sent_n      = sent_q + 1'b1;
`endif
                    if (remaining_q == COUNT_WIDTH'(1)) begin
                        state_n = EOP;
                        eop_n   = 1'b1;
                        data_n  = trailer_last;
                    end else begin
                        data_n  = value_q + STEP_W;
                    end
                end
            end
            EOP: begin
                if (xfer) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    eop_n   = 1'b0;
                    data_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                sop_n   = 1'b0;
                eop_n   = 1'b0;
                data_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            value_q     <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            data_q      <= '0;
`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
            checksum_q  <= '0;
`else
            sent_q      <= '0;
`endif
        end else begin
            state_q     <= state_n;
            value_q     <= value_n;
            remaining_q <= remaining_n;
            valid_q     <= valid_n;
            sop_q       <= sop_n;
            eop_q       <= eop_n;
            data_q      <= data_n;
`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
            checksum_q  <= checksum_n;
`else
            sent_q      <= sent_n;
`endif
        end
    end

endmodule

// File: tb/tb_sequence_source_avalon_st.sv
// tb/tb_sequence_source_avalon_st.sv - randomized self-checking bench for sequence_source_avalon_st
module tb_sequence_source_avalon_st;
    import avalon_st_pkg::*;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int STP  = 1;
    localparam int MASK = (1 << DW) - 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sequence_source_avalon_st_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    sequence_source_avalon_st #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .STEP(STP)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] cap_data[$];
    beat_kind_t    cap_kind[$];
    int            cap_idx[$];
    logic [DW-1:0] exp_data[$];
    beat_kind_t    exp_kind[$];
    int viol, both, rdy_busy, first_valid;
    bit timed_out;

    // Reference packet: header = count, data = start + i*STEP, trailer = sum or count.
    function automatic void build_expected(input int start, input int count);
        int sum;
        int v;
        sum = 0;
        exp_data.delete();
        exp_kind.delete();
        exp_data.push_back(DW'(count & MASK));
        exp_kind.push_back(BEAT_SOP);
        for (int i = 0; i < count; i++) begin
            v = (start + i * STP) & MASK;
            sum += v;
            exp_data.push_back(DW'(v));
            exp_kind.push_back(BEAT_DATA);
        end
`ifdef SEQUENCE_SOURCE_CHECKSUM_EN
        exp_data.push_back(DW'(sum & MASK));
`else
        exp_data.push_back(DW'(count & MASK));
`endif
        exp_kind.push_back(BEAT_EOP);
    endfunction

    task automatic send_cmd(input int s, input int c);
        int n;
        n = 0;
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = s[DW-1:0];
        bus.cmd_count = c[CW-1:0];
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL cmd_accept_timeout got cmd_ready=%b exp 1", bus.cmd_ready);
        end
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: fixed 1,0,0,1,0,1 pattern
    task automatic collect(input int mode);
        logic          stalled, held_s, held_e, r;
        logic [DW-1:0] held_d;
        int            pat [6];
        pat = '{1, 0, 0, 1, 0, 1};
        cap_data.delete(); cap_kind.delete(); cap_idx.delete();
        viol = 0; both = 0; rdy_busy = 0; first_valid = -1; timed_out = 1'b1;
        stalled = 1'b0; held_d = '0; held_s = 1'b0; held_e = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = 1'(pat[i % 6]);
            endcase
            bus.out_ready = r;
            if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held_d ||
                            bus.out_startofpacket !== held_s || bus.out_endofpacket !== held_e))
                viol++;
            if (bus.out_startofpacket === 1'b1 && bus.out_endofpacket === 1'b1) both++;
            if (bus.out_valid === 1'b1 && bus.cmd_ready !== 1'b0) rdy_busy++;
            if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = i;
            stalled = 1'b0;
            if (bus.out_valid === 1'b1) begin
                if (r) begin
                    cap_data.push_back(bus.out_data);
                    cap_kind.push_back(beat_kind(bus.out_startofpacket, bus.out_endofpacket));
                    cap_idx.push_back(i);
                    if (bus.out_endofpacket === 1'b1) begin
                        timed_out = 1'b0;
                        break;
                    end
                end else begin
                    stalled = 1'b1;
                    held_d  = bus.out_data;
                    held_s  = bus.out_startofpacket;
                    held_e  = bus.out_endofpacket;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_startofpacket !== 1'b0 || bus.out_endofpacket !== 1'b0 ||
            bus.out_data !== '0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b s=%b e=%b d=%0d rdy=%b busy=%b exp 0 0 0 0 1 0",
                     bus.out_valid, bus.out_startofpacket, bus.out_endofpacket,
                     bus.out_data, bus.cmd_ready, bus.busy);
        end
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        build_expected(3, 4);
        send_cmd(3, 4);
        collect(0);
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL basic_len got %0d exp %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                errors++;
                $display("FAIL basic_beat%0d got %0d/%0d exp %0d/%0d", i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
            end
        end
        checks++;
        if (timed_out || first_valid != 0 || cap_idx.size() != 6 || cap_idx[$] - cap_idx[0] != 5 || rdy_busy != 0) begin
            errors++;
            $display("FAIL basic_timing got first=%0d beats=%0d rdy_busy=%0d to=%b exp 0 6 0 0",
                     first_valid, cap_idx.size(), rdy_busy, timed_out);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after_eop got rdy=%b busy=%b v=%b exp 1 0 0", bus.cmd_ready, bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_empty();
        build_expected(7, 0);
        send_cmd(7, 0);
        collect(0);
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL empty_len got %0d exp %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                errors++;
                $display("FAIL empty_beat%0d got %0d/%0d exp %0d/%0d", i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
            end
        end
        checks++;
        if (both != 0 || timed_out) begin
            errors++;
            $display("FAIL empty_flags got both=%0d to=%b exp 0 0", both, timed_out);
        end
    endtask

    task automatic test_wrap();
        build_expected(250, 8);
        send_cmd(250, 8);
        collect(0);
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL wrap_len got %0d exp %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                errors++;
                $display("FAIL wrap_beat%0d got %0d/%0d exp %0d/%0d", i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
            end
        end
    endtask

    task automatic test_stall();
        build_expected(1, 3);
        send_cmd(1, 3);
        collect(2);
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL stall_len got %0d exp %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                errors++;
                $display("FAIL stall_beat%0d got %0d/%0d exp %0d/%0d", i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
            end
        end
        checks++;
        if (viol != 0 || timed_out) begin
            errors++;
            $display("FAIL stall_hold got viol=%0d to=%b exp 0 0", viol, timed_out);
        end
    endtask

    task automatic test_back_to_back();
        build_expected(9, 2);
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = 8'd9;
        bus.cmd_count = 8'd2;
        @(posedge clock);
        #1;
        collect(0);
        checks++;
        if (cap_data.size() != exp_data.size() || rdy_busy != 0 || timed_out) begin
            errors++;
            $display("FAIL b2b_first got len=%0d rdy_busy=%0d to=%b exp %0d 0 0", cap_data.size(), rdy_busy, timed_out, exp_data.size());
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap got rdy=%b v=%b exp 1 0", bus.cmd_ready, bus.out_valid);
        end
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_startofpacket !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_sop got v=%b s=%b rdy=%b exp 1 1 0", bus.out_valid, bus.out_startofpacket, bus.cmd_ready);
        end
        collect(0);
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL b2b_len got %0d exp %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got %0d/%0d exp %0d/%0d", i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        send_cmd(0, 5);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            bus.out_ready = 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_startofpacket === 1'b0 && bus.out_data === 8'd2) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_reach got seen=0 exp 1");
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_startofpacket !== 1'b0 || bus.out_endofpacket !== 1'b0 ||
            bus.out_data !== '0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got v=%b s=%b e=%b d=%0d rdy=%b busy=%b exp 0 0 0 0 1 0",
                     bus.out_valid, bus.out_startofpacket, bus.out_endofpacket,
                     bus.out_data, bus.cmd_ready, bus.busy);
        end
        @(negedge clock);
        reset = 1'b0;
        build_expected(0, 5);
        send_cmd(0, 5);
        collect(0);
        checks++;
        if (cap_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL rstmid_len got %0d exp %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            checks++;
            if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                errors++;
                $display("FAIL rstmid_beat%0d got %0d/%0d exp %0d/%0d", i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
            end
        end
    endtask

    task automatic test_random();
        int s, c, m;
        for (int p = 0; p < 25; p++) begin
            s = int'($urandom_range(0, MASK));
            c = (p == 24) ? (1 << CW) - 1 : int'($urandom_range(0, 12));
            m = (p == 24) ? 0 : int'($urandom_range(0, 1));
            build_expected(s, c);
            send_cmd(s, c);
            collect(m);
            checks++;
            if (cap_data.size() != exp_data.size() || viol != 0 || both != 0 || rdy_busy != 0 || timed_out) begin
                errors++;
                $display("FAIL rand%0d_frame got len=%0d viol=%0d both=%0d rdy_busy=%0d to=%b exp len=%0d 0 0 0 0",
                         p, cap_data.size(), viol, both, rdy_busy, timed_out, exp_data.size());
            end
            for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
                checks++;
                if (cap_data[i] !== exp_data[i] || cap_kind[i] !== exp_kind[i]) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d got %0d/%0d exp %0d/%0d", p, i, cap_data[i], cap_kind[i], exp_data[i], exp_kind[i]);
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_start = '0;
        bus.cmd_count = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_empty();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
